four_bank_mem_resp: RTL and testbench

//  Responder end of the cache<->main-memory interface: a 4-bank, word-interleaved main memory

---
 rtl/four_bank_mem_resp_pkg.sv | 13 +
 rtl/four_bank_mem_resp_bank.sv | 44 ++++
 rtl/four_bank_mem_resp.sv | 81 ++++++++
 tb/tb_four_bank_mem_resp.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/four_bank_mem_resp_pkg.sv
// Shared constants for the four-bank interleaved main-memory responder.
package four_bank_mem_resp_pkg;
  localparam int NUM_BANKS       = 4;
  localparam int BANK_SEL_LSB    = 1;
  localparam int BANK_SEL_W      = 2;
  localparam int BUSY_CYCLES_DEF = 4;
  localparam int READ_LAT_DEF    = 2;

  // Counter width that can hold BUSY_CYCLES-1
  function automatic int cnt_width(input int busy_cycles);
    return $clog2(busy_cycles) + 1;
  endfunction
endpackage

// File: rtl/four_bank_mem_resp_bank.sv
// One memory bank: storage, occupancy counter, write port and sampled read port.
module mem_bank
  import four_bank_mem_resp_pkg::*;
#(
  parameter int ROW_W       = 13,
  parameter int DATA_W      = 16,
  parameter int BUSY_CYCLES = BUSY_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_i,
  input  logic              wr_i,
  input  logic [ROW_W-1:0]  row_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int CNT_W = cnt_width(BUSY_CYCLES);

  logic [DATA_W-1:0] mem_q [2**ROW_W];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q;

  // Accept only happens with the counter at zero, so reload never meets a decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (acc_i)              cnt_d = CNT_W'(BUSY_CYCLES - 1);
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Array contents survive reset; acc_i is already masked by reset upstream.
  always_ff @(posedge clk) begin
    if (acc_i && wr_i)  mem_q[row_i] <= wdata_i;
    if (acc_i && !wr_i) rdata_q      <= mem_q[row_i];
  end

  assign busy_o  = (cnt_q != '0);
  assign rdata_o = rdata_q;
endmodule

// File: rtl/four_bank_mem_resp.sv
// Word-interleaved 4-bank main memory answering cache mem_rd/mem_wr requests.
module four_bank_mem_resp
  import four_bank_mem_resp_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BUSY_CYCLES = BUSY_CYCLES_DEF,
  parameter int READ_LAT    = READ_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 wr,
  input  logic                 rd,
  output logic [DATA_W-1:0]    data_out,
  output logic                 stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);
  localparam int ROW_W = ADDR_W - BANK_SEL_LSB - BANK_SEL_W;

  logic [BANK_SEL_W-1:0]              bank;
  logic [ROW_W-1:0]                   row;
  logic                               acc;
  logic [NUM_BANKS-1:0][DATA_W-1:0]   bank_rdata;
  logic [READ_LAT:1]                  vld_pipe;
  logic [BANK_SEL_W-1:0]              bsel_q;
  logic [DATA_W-1:0]                  rd_sel, head_data;

  assign bank  = addr[BANK_SEL_LSB +: BANK_SEL_W];
  assign row   = addr[ADDR_W-1 -: ROW_W];
  assign err   = (rd & wr) | ((rd | wr) & addr[0]);
  // rd^wr is already 0 for the dual request, so err wins over stall without extra gating.
  assign stall = (rd ^ wr) & ~addr[0] & busy[bank];
  assign acc   = (rd ^ wr) & ~err & ~stall & ~rst;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mem_bank #(
      .ROW_W      (ROW_W),
      .DATA_W     (DATA_W),
      .BUSY_CYCLES(BUSY_CYCLES)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .acc_i  (acc && (bank == BANK_SEL_W'(b))),
      .wr_i   (wr),
      .row_i  (row),
      .wdata_i(data_in),
      .busy_o (busy[b]),
      .rdata_o(bank_rdata[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      bsel_q   <= '0;
    end else begin
      vld_pipe[1] <= acc & rd;
      for (int k = 2; k <= READ_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
      if (acc && rd) bsel_q <= bank;
    end
  end

  // Bank output is already one stage; remaining READ_LAT-1 stages carry data only.
  assign rd_sel = bank_rdata[bsel_q];

  if (READ_LAT == 1) begin : g_lat1
    assign head_data = rd_sel;
  end else begin : g_dly
    logic [READ_LAT-1:1][DATA_W-1:0] dly_q;
    always_ff @(posedge clk) begin
      dly_q[1] <= rd_sel;
      for (int k = 2; k <= READ_LAT-1; k++) dly_q[k] <= dly_q[k-1];
    end
    assign head_data = dly_q[READ_LAT-1];
  end

  assign data_out = vld_pipe[READ_LAT] ? head_data : '0;
endmodule

// File: tb/tb_four_bank_mem_resp.sv
// Directed bench for four_bank_mem_resp with hand-computed expectations.
module tb_four_bank_mem_resp;
  logic        clk = 1'b0;
  logic        rst, rd, wr;
  logic [15:0] addr, data_in, data_out;
  logic        stall, err;
  logic [3:0]  busy;

  int n_chk  = 0;
  int n_fail = 0;

  four_bank_mem_resp dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .data_in (data_in),
    .wr      (wr),
    .rd      (rd),
    .data_out(data_out),
    .stall   (stall),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one cycle, drive new inputs, then land on the negedge for checking.
  task automatic step(input logic rs, input logic r, input logic w,
                      input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    rst = rs; rd = r; wr = w; addr = a; data_in = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0, 16'h0);
  endtask

  initial begin
    rst = 1'b1; rd = 1'b1; wr = 1'b0; addr = 16'h0; data_in = 16'h0;
    // 1: reset held two cycles with a read asserted
    @(negedge clk);
    step(1, 1, 0, 16'h0000, 16'h0);
    chk("rst_busy", busy, 4'b0000);
    chk("rst_dout", data_out, 16'h0);
    step(0, 0, 0, 16'h0, 16'h0);
    chk("rel_busy", busy, 4'b0000);
    chk("rel_dout", data_out, 16'h0);
    step(0, 0, 0, 16'h0, 16'h0);
    chk("rel_dout2", data_out, 16'h0);

    // preload bank1 row1 for the stall test
    step(0, 0, 1, 16'h000A, 16'h5A5A);
    idle(4);

    // 2: write then read same address
    step(0, 0, 1, 16'h0010, 16'hBEEF);
    chk("t2_stall", stall, 1'b0);
    chk("t2_err", err, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 16'h0, 16'h0);
      chk("t2_busy", busy, 4'b0001);
      chk("t2_dout0", data_out, 16'h0);
    end
    step(0, 1, 0, 16'h0010, 16'h0);
    chk("t2_rd_stall", stall, 1'b0);
    chk("t2_busy_free", busy, 4'b0000);
    step(0, 0, 0, 16'h0, 16'h0);
    chk("t2_dout_t5", data_out, 16'h0);
    chk("t2_busy_t5", busy, 4'b0001);
    step(0, 0, 0, 16'h0, 16'h0);
    chk("t2_dout_t6", data_out, 16'hBEEF);
    step(0, 0, 0, 16'h0, 16'h0);
    chk("t2_dout_t7", data_out, 16'h0);
    idle(3);

    // 3: same-bank request stalls until the bank frees
    step(0, 0, 1, 16'h0002, 16'h1234);
    chk("t3_wr_stall", stall, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 0, 16'h000A, 16'h0);
      chk("t3_stall", stall, 1'b1);
      chk("t3_err", err, 1'b0);
      chk("t3_busy", busy, 4'b0010);
    end
    step(0, 1, 0, 16'h000A, 16'h0);
    chk("t3_accept", stall, 1'b0);
    chk("t3_busy_t4", busy, 4'b0000);
    step(0, 0, 0, 16'h0, 16'h0);
    chk("t3_busy_t5", busy, 4'b0010);
    chk("t3_dout_t5", data_out, 16'h0);
    step(0, 0, 0, 16'h0, 16'h0);
    chk("t3_dout_t6", data_out, 16'h5A5A);
    idle(4);

    // preload all four banks, row 0, back to back
    step(0, 0, 1, 16'h0000, 16'h1111); chk("pre_stall0", stall, 1'b0);
    step(0, 0, 1, 16'h0002, 16'h2222); chk("pre_stall1", stall, 1'b0);
    step(0, 0, 1, 16'h0004, 16'h3333); chk("pre_stall2", stall, 1'b0);
    step(0, 0, 1, 16'h0006, 16'h4444); chk("pre_stall3", stall, 1'b0);
    idle(4);

    // 4: interleaved reads, one per cycle
    step(0, 1, 0, 16'h0000, 16'h0); chk("t4_stall0", stall, 1'b0);
    step(0, 1, 0, 16'h0002, 16'h0); chk("t4_stall1", stall, 1'b0);
    step(0, 1, 0, 16'h0004, 16'h0); chk("t4_stall2", stall, 1'b0);
    chk("t4_dout_t2", data_out, 16'h1111);
    step(0, 1, 0, 16'h0006, 16'h0); chk("t4_stall3", stall, 1'b0);
    chk("t4_dout_t3", data_out, 16'h2222);
    chk("t4_busy_t3", busy, 4'b0111);
    step(0, 0, 0, 16'h0, 16'h0);
    chk("t4_dout_t4", data_out, 16'h3333);
    chk("t4_busy_t4", busy, 4'b1110);
    step(0, 0, 0, 16'h0, 16'h0);
    chk("t4_dout_t5", data_out, 16'h4444);
    step(0, 0, 0, 16'h0, 16'h0);
    chk("t4_dout_t6", data_out, 16'h0);
    idle(4);

    // 5: illegal requests
    step(0, 1, 0, 16'h0011, 16'h0);
    chk("t5_odd_err", err, 1'b1);
    chk("t5_odd_stall", stall, 1'b0);
    step(0, 0, 0, 16'h0, 16'h0);
    chk("t5_odd_busy", busy, 4'b0000);
    step(0, 1, 1, 16'h0004, 16'hDEAD);
    chk("t5_both_err", err, 1'b1);
    chk("t5_both_stall", stall, 1'b0);
    step(0, 0, 0, 16'h0, 16'h0);
    chk("t5_both_busy", busy, 4'b0000);
    // err beats stall on a busy bank
    step(0, 0, 1, 16'h0000, 16'h1111);
    step(0, 1, 0, 16'h0001, 16'h0);
    chk("t5_prio_err", err, 1'b1);
    chk("t5_prio_stall", stall, 1'b0);
    idle(4);
    step(0, 1, 0, 16'h0004, 16'h0);
    idle(2);
    chk("t5_nowrite", data_out, 16'h3333);
    idle(4);

    // 6: reset while a read is in flight
    step(0, 1, 0, 16'h0006, 16'h0);
    chk("t6_accept", stall, 1'b0);
    step(1, 0, 0, 16'h0, 16'h0);
    step(0, 1, 0, 16'h0006, 16'h0);
    chk("t6_dout_t2", data_out, 16'h0);
    chk("t6_busy_t2", busy, 4'b0000);
    chk("t6_stall_t2", stall, 1'b0);
    step(0, 0, 0, 16'h0, 16'h0);
    chk("t6_busy_t3", busy, 4'b1000);
    chk("t6_dout_t3", data_out, 16'h0);
    step(0, 0, 0, 16'h0, 16'h0);
    chk("t6_dout_t4", data_out, 16'h4444);
    step(0, 0, 0, 16'h0, 16'h0);
    chk("t6_dout_t5", data_out, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
